plot_clip_fifo: RTL
===================

PLOT_CLIP_FIFO -- requirements
Module: plot_clip_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, storage depth in pixels (power of 2, 4..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: clear  input  1  synchronous flush of contents and status.
REQ-005 SHALL have port: in_x  input  8  pixel x from the drawing engine.
REQ-006 SHALL have port: in_y  input  7  pixel y from the drawing engine.
REQ-007 SHALL have port: in_colour  input  3  pixel colour.
REQ-008 SHALL have port: in_plot  input  1  pixel valid; no backpressure is offered upstream.
REQ-009 SHALL have port: vga_x  output  8  head pixel x toward the VGA adapter.
REQ-010 SHALL have port: vga_y  output  7  head pixel y.
REQ-011 SHALL have port: vga_colour  output  3  head pixel colour.
REQ-012 SHALL have port: vga_plot  output  1  head pixel valid.
REQ-013 SHALL have port: vga_ready  input  1  adapter accepts head pixel this cycle.
REQ-014 SHALL have port: level  output  clog2(DEPTH)+1  stored pixel count.
REQ-015 SHALL have port: overflow  output  1  sticky: a pixel was dropped because storage was full.
REQ-016 SHALL have port: drop_count  output  8  saturating count of full-drops.
REQ-017 SHALL have port: clip_count  output  8  saturating count of off-screen pixels.

Function
REQ-018 SHALL treat a pixel as off-screen when in_x >= 160 or in_y >= 120.
- On in_plot with an off-screen pixel: not stored; clip_count increments, saturating at 255.
REQ-019 SHALL push an on-screen pixel when in_plot=1 and either level < DEPTH or a pop occurs on the same edge.
REQ-020 SHALL drop an on-screen pixel when in_plot=1, level = DEPTH and no pop occurs on that edge.
- On a drop: overflow is set to 1; drop_count increments, saturating at 255.
REQ-021 SHALL drive vga_plot = (level != 0).
- vga_x/vga_y/vga_colour SHALL equal the oldest stored pixel; all three SHALL be 0 when level = 0.
REQ-022 SHALL pop on an edge where vga_plot=1 and vga_ready=1.
- Outputs SHALL hold stable while vga_plot=1 and vga_ready=0.
REQ-023 SHALL make a pushed pixel visible on vga_* in the cycle immediately after the accepting edge when the FIFO was empty.
- Latency: 1 cycle, no bypass.
REQ-024 SHALL on simultaneous push and pop keep level unchanged and preserve FIFO order.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL on clear=1 empty storage and zero level, overflow, drop_count and clip_count.
- Clear SHALL take priority over a same-edge push or pop; the input pixel on that edge is discarded uncounted.
REQ-027 SHALL keep vga_plot free of any combinational path from in_plot.

Reset
REQ-028 SHALL on rst=1, immediately and regardless of clk, force level=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, overflow=0, drop_count=0, clip_count=0, pointers=0.
REQ-029 SHALL discard all stored pixels when rst asserts mid-operation.
- The first pixel accepted after rst deasserts SHALL be the first pixel emitted.

Structure
REQ-030 SHALL take SCREEN_W=160, SCREEN_H=120 and the packed pixel_t {x[7:0], y[6:0], colour[2:0]} from shared package plot_pkg.
REQ-031 SHALL instantiate one generic sub-module sync_fifo (pixel_t data, DEPTH, push/pop/level).
- Clip logic, counters and sticky flag SHALL reside in plot_clip_fifo.

Verification
REQ-032 SHALL cover reset: assert rst mid-stream with level=5 -> all outputs 0 at once; after release, push (40,78,3) -> vga_* = (40,78,3), vga_plot=1 next cycle.
REQ-033 SHALL cover passthrough: vga_ready=1, push (38,81,1) then (42,80,1) on consecutive edges -> emitted in that order, one per cycle, level returns to 0.
REQ-034 SHALL cover clipping: push (160,10,2) and (5,120,2) -> level stays 0, clip_count=2, vga_plot=0.
REQ-035 SHALL cover full and overflow: vga_ready=0, DEPTH=16, push 17 on-screen pixels -> level=16, overflow=1, drop_count=1; head equals the first pixel pushed.
REQ-036 SHALL cover full with simultaneous pop: at level=16, push with vga_ready=1 -> level stays 16, overflow unchanged, new pixel emitted 16th after the current head.
REQ-037 SHALL cover clear: clear=1 with a concurrent push at level=7 -> next cycle level=0, counters=0, vga_plot=0, pushed pixel absent.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared pixel definitions for the plot path: screen bounds, packed pixel
// record and the off-screen test used by the clip stage.
package plot_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  function automatic logic is_offscreen(input logic [7:0] x, input logic [6:0] y);
    return (x >= SCREEN_W) || (y >= SCREEN_H);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock pixel FIFO; head is read combinationally from storage
// and forced to zero while empty, so it only depends on registered state.
module sync_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  pixel_t        din,
  output pixel_t        dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == DEPTH_L);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/plot_clip_fifo.sv
// Buffers pixels between the drawing engine and the VGA adapter, discarding
// off-screen pixels and counting clips and full-drops.
module plot_clip_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [7:0]    in_x,
  input  logic [6:0]    in_y,
  input  logic [2:0]    in_colour,
  input  logic          in_plot,
  output logic [7:0]    vga_x,
  output logic [6:0]    vga_y,
  output logic [2:0]    vga_colour,
  output logic          vga_plot,
  input  logic          vga_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_count,
  output logic [7:0]    clip_count
);

  pixel_t din;
  pixel_t head;
  logic   full;
  logic   empty;
  logic   offscreen;
  logic   onscreen_plot;
  logic   pop;
  logic   push;
  logic   drop;
  logic   clip;

  assign din       = '{x: in_x, y: in_y, colour: in_colour};
  assign offscreen = is_offscreen(in_x, in_y);
  assign clip      = in_plot & offscreen;
  assign onscreen_plot = in_plot & ~offscreen;

  // vga_plot comes from the registered level only, never from in_plot.
  assign vga_plot = ~empty;
  assign pop      = vga_plot & vga_ready;
  assign push     = onscreen_plot & (~full | pop);
  assign drop     = onscreen_plot & full & ~pop;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign vga_x      = head.x;
  assign vga_y      = head.y;
  assign vga_colour = head.colour;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      clip_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      clip_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      if (clip && clip_count != 8'hFF) clip_count <= clip_count + 8'd1;
    end
  end

endmodule
